// File: rtl/pipe_defs.sv
// Shared pipeline definitions: the MUL/DIV op codes (these must track the stage_id decode
// table) and the multiply/divide sequencer state encodings.
package pipe_defs;

   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1100;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   typedef enum logic {
      MD_KIND_MUL = 1'b0,
      MD_KIND_DIV = 1'b1
   } md_kind_t;

   function automatic logic is_md_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration of the shared datapath: a shift-add step for MUL,
// or a restoring shift-subtract step for DIV.
module md_step
   import pipe_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  md_kind_t         kind,
   input  logic [WIDTH:0]   part,
   input  logic             op_bit,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH:0]   part_nxt,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] sum;
   logic             unused_part_msb;

   // The kept remainder is always below the divisor, so its top bit never carries information.
   assign unused_part_msb = part[WIDTH];

   always_comb begin
      shifted  = {part[WIDTH-1:0], op_bit};
      diff     = shifted - {1'b0, operand};
      sum      = part[WIDTH-1:0] + (op_bit ? operand : '0);
      part_nxt = part;
      q_bit    = 1'b0;
      if (kind == MD_KIND_MUL) begin
         part_nxt = {1'b0, sum};
      end else if (!diff[WIDTH]) begin
         part_nxt = diff;
         q_bit    = 1'b1;
      end else begin
         part_nxt = shifted;
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage iterative multiply/divide sequencer: it stalls the front end for WIDTH iterations,
// then presents the result and destination register for a single cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | no operation in flight; waiting for a MUL/DIV start
//   MD_BUSY | iterating, counter 0..WIDTH-1, stall held
//   MD_DONE | ans_md/rw_md valid for one cycle; may accept the next op
module ex_muldiv_seq
   import pipe_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic [3:0]       op_ex,
   input  logic [WIDTH-1:0] a_ex,
   input  logic [WIDTH-1:0] b_ex,
   input  logic [4:0]       rw_in,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] ans_md,
   output logic [4:0]       rw_md
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_t        state, state_nxt;
   md_kind_t         kind;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   part;
   logic [WIDTH-1:0] quo;
   logic [4:0]       rw_lat;

   logic             accept;
   logic             last;
   logic             op_bit;
   logic [WIDTH-1:0] operand;
   logic [WIDTH:0]   part_nxt;
   logic             q_bit;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= MD_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      accept    = 1'b0;
      last      = 1'b0;
      stall     = 1'b0;
      done      = 1'b0;
      state_nxt = state;
      case (state)
         MD_IDLE: begin
            accept = start && is_md_op(op_ex) && !flush;
            if (accept) state_nxt = MD_BUSY;
         end
         MD_BUSY: begin
            last = (cnt == LAST);
            if (last) state_nxt = MD_DONE;
         end
         MD_DONE: begin
            done   = 1'b1;
            accept = start && is_md_op(op_ex) && !flush;
            state_nxt = accept ? MD_BUSY : MD_IDLE;
         end
         default: state_nxt = MD_IDLE;
      endcase
      // A squash wins over everything, including the stall that would hold the squashed op.
      if (flush) begin
         state_nxt = MD_IDLE;
         last      = 1'b0;
      end else begin
         stall = accept || (state == MD_BUSY);
      end
   end

   // MUL walks the multiplier LSB-first against a left-shifting multiplicand;
   // DIV walks the dividend MSB-first against a fixed divisor.
   assign op_bit  = (kind == MD_KIND_MUL) ? opb[0] : opa[WIDTH-1];
   assign operand = (kind == MD_KIND_MUL) ? opa : opb;

   md_step #(.WIDTH(WIDTH)) u_step (
      .kind     (kind),
      .part     (part),
      .op_bit   (op_bit),
      .operand  (operand),
      .part_nxt (part_nxt),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         kind   <= MD_KIND_MUL;
         cnt    <= '0;
         opa    <= '0;
         opb    <= '0;
         part   <= '0;
         quo    <= '0;
         rw_lat <= '0;
         ans_md <= '0;
         rw_md  <= '0;
      end else if (accept) begin
         kind   <= (op_ex == OP_DIV) ? MD_KIND_DIV : MD_KIND_MUL;
         cnt    <= '0;
         opa    <= a_ex;
         opb    <= b_ex;
         part   <= '0;
         quo    <= '0;
         rw_lat <= rw_in;
      end else if (state == MD_BUSY && !flush) begin
         cnt  <= cnt + 1'b1;
         part <= part_nxt;
         quo  <= {quo[WIDTH-2:0], q_bit};
         opa  <= {opa[WIDTH-2:0], 1'b0};
         if (kind == MD_KIND_MUL) opb <= {1'b0, opb[WIDTH-1:1]};
         if (last) begin
            ans_md <= (kind == MD_KIND_MUL) ? part_nxt[WIDTH-1:0] : {quo[WIDTH-2:0], q_bit};
            rw_md  <= rw_lat;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: expected results are queued at issue and popped at done.
module tb_ex_muldiv_seq;
   localparam int WIDTH = 32;
   localparam logic [3:0] OPC_MUL = 4'b1000;
   localparam logic [3:0] OPC_DIV = 4'b1100;

   logic             clk;
   logic             clrn;
   logic             start;
   logic [3:0]       op_ex;
   logic [WIDTH-1:0] a_ex;
   logic [WIDTH-1:0] b_ex;
   logic [4:0]       rw_in;
   logic             flush;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] ans_md;
   logic [4:0]       rw_md;

   typedef struct {
      logic [WIDTH-1:0] ans;
      logic [4:0]       rw;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   ex_muldiv_seq #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .clrn   (clrn),
      .start  (start),
      .op_ex  (op_ex),
      .a_ex   (a_ex),
      .b_ex   (b_ex),
      .rw_in  (rw_in),
      .flush  (flush),
      .stall  (stall),
      .done   (done),
      .ans_md (ans_md),
      .rw_md  (rw_md)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [WIDTH-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] p;
      if (op == OPC_MUL) begin
         p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
         return p[WIDTH-1:0];
      end
      if (b == '0) return '1;
      return a / b;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive an op for one cycle (the accept cycle T); returns at T+1 with start dropped.
   task automatic issue(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [4:0] rw);
      exp_t e;
      start = 1'b1;
      op_ex = op;
      a_ex  = a;
      b_ex  = b;
      rw_in = rw;
      #1;
      check({tag, "_accept_stall"}, 64'(stall), 64'd1);
      e.ans = model(op, a, b);
      e.rw  = rw;
      exp_q.push_back(e);
      cyc();
      start = 1'b0;
      op_ex = 4'b0000;
      a_ex  = $urandom;
      b_ex  = $urandom;
      rw_in = 5'($urandom);
   endtask

   // Entered at T+1; the done pulse is required at T+33, i.e. after exactly 32 more cycles.
   task automatic wait_done(input string tag);
      int   n = 0;
      logic bad_stall = 1'b0;
      exp_t e;
      while (done !== 1'b1 && n < 40) begin
         if (stall !== 1'b1) bad_stall = 1'b1;
         cyc();
         n++;
      end
      check({tag, "_busy_stall"}, 64'(bad_stall), 64'd0);
      check({tag, "_latency"}, 64'(n), 64'd32);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_done_stall"}, 64'(stall), 64'd0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_ans"}, 64'(ans_md), 64'(e.ans));
         check({tag, "_rw"}, 64'(rw_md), 64'(e.rw));
      end
   endtask

   initial begin
      logic seen;
      clrn  = 1'b0;
      start = 1'b0;
      op_ex = 4'b0000;
      a_ex  = '0;
      b_ex  = '0;
      rw_in = '0;
      flush = 1'b0;
      #12;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ans", 64'(ans_md), 64'd0);
      check("rst_rw", 64'(rw_md), 64'd0);
      clrn = 1'b1;
      cyc();

      issue("mul_7x6", OPC_MUL, 32'd7, 32'd6, 5'd5);
      wait_done("mul_7x6");
      cyc();
      issue("mul_ovf0", OPC_MUL, 32'h0001_0000, 32'h0001_0000, 5'd6);
      wait_done("mul_ovf0");
      issue("mul_ovf1", OPC_MUL, 32'hFFFF_FFFF, 32'd2, 5'd7);
      wait_done("mul_ovf1");
      cyc();
      issue("div_100_7", OPC_DIV, 32'd100, 32'd7, 5'd8);
      wait_done("div_100_7");
      cyc();
      issue("div_max_1", OPC_DIV, 32'hFFFF_FFFF, 32'd1, 5'd9);
      wait_done("div_max_1");
      cyc();
      issue("div_by0", OPC_DIV, 32'd5, 32'd0, 5'd10);
      wait_done("div_by0");
      cyc();

      start = 1'b1;
      op_ex = 4'b0000;
      a_ex  = 32'd3;
      b_ex  = 32'd4;
      #1;
      check("nonmd_stall", 64'(stall), 64'd0);
      cyc();
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (stall !== 1'b0 || done !== 1'b0) seen = 1'b1;
         cyc();
      end
      check("nonmd_quiet", 64'(seen), 64'd0);

      issue("b2b_div", OPC_DIV, 32'd100, 32'd7, 5'd11);
      wait_done("b2b_div");
      issue("b2b_mul", OPC_MUL, 32'd3, 32'd4, 5'd12);
      wait_done("b2b_mul");
      cyc();

      issue("flush", OPC_MUL, 32'd9, 32'd9, 5'd13);
      repeat (9) cyc();
      flush = 1'b1;
      #1;
      check("flush_cycle_stall", 64'(stall), 64'd0);
      cyc();
      flush = 1'b0;
      check("flush_idle_stall", 64'(stall), 64'd0);
      void'(exp_q.pop_front());
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done !== 1'b0) seen = 1'b1;
         cyc();
      end
      check("flush_no_done", 64'(seen), 64'd0);

      issue("rst_mid", OPC_MUL, 32'd5, 32'd5, 5'd14);
      repeat (19) cyc();
      check("rst_mid_busy", 64'(stall), 64'd1);
      #1;
      clrn = 1'b0;
      #1;
      check("rst_mid_stall", 64'(stall), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_ans", 64'(ans_md), 64'd0);
      check("rst_mid_rw", 64'(rw_md), 64'd0);
      void'(exp_q.pop_front());
      cyc();
      cyc();
      #2;
      clrn = 1'b1;
      cyc();
      issue("post_rst", OPC_MUL, 32'd2, 32'd3, 5'd15);
      wait_done("post_rst");
      cyc();

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative multiply/divide sequencer for the EX stage. It takes over the MUL (op 1000) and DIV (op 1100) encodings from the single-cycle ALU and computes them over 32 cycles with a shared shift/add-subtract datapath. While it runs, it holds a stall line that freezes IF/ID/EX, then presents the result and destination register for one cycle to the EX/MEM latch.

## Interface
- `WIDTH`, default 32: operand and result width. The iteration count equals `WIDTH`.
- `clk`  in  1  pipeline clock, rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  EX holds a valid instruction this cycle.
- `op_ex`  in  4  ALU op code. Only 1000 (MUL) and 1100 (DIV) are accepted.
- `a_ex`, `b_ex`  in  WIDTH  operands; MUL computes a*b, DIV computes a/b.
- `rw_in`  in  5  destination register of the issuing instruction.
- `flush`  in  1  cancel any in-flight operation (branch/exception squash).
- `stall`  out  1  freeze IF/ID/EX this cycle.
- `done`  out  1  `ans_md`/`rw_md` valid this cycle.
- `ans_md`  out  WIDTH  MUL: low WIDTH bits of the product. DIV: the quotient.
- `rw_md`  out  5  destination register associated with `ans_md`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start` with a MUL/DIV op latches a, b, rw and the op kind, clears the counter and goes to BUSY.
  - Any other op is ignored and the state stays IDLE.
- BUSY: one iteration per cycle on the counter, which runs 0..WIDTH-1.
  - After the iteration with count = WIDTH-1, go to DONE.
- DONE: `done`=1 for exactly one cycle.
  - A new accepted `start` in DONE goes directly to BUSY (back-to-back issue).
  - Otherwise go to IDLE.
- MUL: unsigned shift-add. Each iteration, if multiplier bit i = 1, add the multiplicand shifted left by i to a WIDTH-bit accumulator. Overflow beyond WIDTH bits is discarded.
- DIV: unsigned restoring division with a WIDTH+1-bit partial remainder.
  - Each iteration shifts in the next dividend bit MSB-first.
  - Subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - The remainder is discarded.
- Divide by zero: no special path. The restoring loop naturally yields quotient all-ones (0xFFFFFFFF).
- `stall` = (IDLE or DONE) & `start` & is_md, or BUSY. `stall` is 0 in DONE unless a new MUL/DIV is being accepted, so the pipeline advances and captures `ans_md`.
- `flush` has priority over `start` and over iteration.
  - In any state, flush forces IDLE next cycle and drops the latched op; no `done` follows.
  - `stall` in a flush cycle is 0.
- Outputs in IDLE and BUSY: `done`=0. `ans_md` and `rw_md` hold their last values and are valid only when `done`=1.
- Reset values: state IDLE; counter, accumulator, remainder, quotient, `ans_md`, `rw_md` all 0; `stall`=0; `done`=0.

## Timing
- Accept cycle T (IDLE, start, MUL/DIV): `stall`=1 combinationally in T.
- BUSY from T+1 to T+32 inclusive, with `stall`=1.
- DONE at T+33: `done`=1, `stall`=0, and `ans_md`/`rw_md` are registered values.
- Total occupancy is 34 cycles, of which 33 are stalled.
- Back-to-back: an accept in DONE cycle D gives the next DONE at D+33.
- Reset mid-BUSY: the result is lost, and outputs are at reset values immediately (asynchronous).
- Operands are sampled only in the accept cycle. Changes on `a_ex`/`b_ex` during BUSY are ignored.

## Structure
- Shared package/include `pipe_defs`:
  - Op codes `OP_MUL`=4'b1000 and `OP_DIV`=4'b1100. These must match the decode table in `stage_id`.
  - State encodings `MD_IDLE`=2'd0, `MD_BUSY`=2'd1, `MD_DONE`=2'd2.
- One natural sub-module, `md_step`: combinational single-iteration datapath.
  - Inputs: op kind, accumulator/remainder, operand bit, divisor/multiplicand.
  - Outputs: next accumulator/remainder and the quotient bit.
- The FSM, counter and registers stay in `ex_muldiv_seq`.
- Integration: `stage_ex` selects `ans_md` over the ALU result when `done`=1, and `rw_md` over `rw_ex` at the same time.

## Test plan
- MUL basic: a=7, b=6, rw=5, start at T -> `stall` high T..T+32; at T+33 `done`=1, `ans_md`=42, `rw_md`=5, `stall`=0.
- MUL overflow: a=0x10000, b=0x10000 -> `ans_md`=0x00000000. Then a=0xFFFFFFFF, b=2 -> `ans_md`=0xFFFFFFFE.
- DIV cases:
  - a=100, b=7 -> `ans_md`=14.
  - a=0xFFFFFFFF, b=1 -> `ans_md`=0xFFFFFFFF.
  - a=5, b=0 -> `ans_md`=0xFFFFFFFF, with no hang; `done` at T+33.
- Non-MD op: start with op 0000 -> `stall`=0 and `done`=0 for the following 40 cycles.
- Back-to-back: DIV 100/7, then MUL 3*4 accepted in the DONE cycle -> two `done` pulses exactly 33 cycles apart, with values 14 then 12; `stall` stays high across the transition.
- Flush and reset:
  - `flush` at T+10 -> IDLE at T+11, no `done` pulse.
  - `clrn` low at T+20 -> `stall`/`done` go 0 asynchronously; after release, a new MUL 2*3 yields 6.
